// File: rtl/spec_rollback_ctrl.sv
// spec_rollback_ctrl: tracks per-register speculation levels and sequences squash/redirect recovery on mispredict
module spec_rollback_ctrl #(
  parameter int NUM_TAG = 4,
  parameter int NUM_REG = 8,
  parameter int SPEC_DEPTH = 4,
  parameter int PC_BIT = 4,
  parameter int INST_ID_BIT = 8,
  parameter int REG_ID_BIT = $clog2(NUM_REG),
  parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     wr_vld,
  input  logic [REG_ID_BIT-1:0]                    wr_reg,
  input  logic [SPEC_LEVEL_BIT-1:0]                cur_spec_level,
  input  logic                                     br_pred_vld,
  input  logic                                     br_pred_succ,
  input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels,
  input  logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level,
  input  logic [NUM_TAG*REG_ID_BIT-1:0]            br_pred_fail_tag_map,
  input  logic [PC_BIT-1:0]                        br_pred_fail_pc,
  input  logic [INST_ID_BIT-1:0]                   br_pred_fail_id,
  output logic                                     busy,
  output logic [NUM_REG-1:0]                       spec_pending,
  output logic                                     squash_vld,
  output logic [REG_ID_BIT-1:0]                    squash_reg,
  input  logic                                     squash_rdy,
  output logic                                     redirect_vld,
  output logic [PC_BIT-1:0]                        redirect_pc,
  output logic [INST_ID_BIT-1:0]                   redirect_id,
  output logic [NUM_TAG*REG_ID_BIT-1:0]            redirect_tag_map,
  input  logic                                     redirect_rdy
);
  typedef enum logic [1:0] {IDLE, SQUASH, REDIRECT} state_t;
  state_t state, state_nxt;
  logic [REG_ID_BIT-1:0] ptr, ptr_nxt;
  logic [SPEC_LEVEL_BIT-1:0] lvl [NUM_REG];
  logic [SPEC_LEVEL_BIT-1:0] lvl_nxt [NUM_REG];
  logic [SPEC_LEVEL_BIT-1:0] nxt_map [SPEC_DEPTH+1];
  logic [NUM_REG-1:0] flag, flag_nxt;
  logic fail;
  assign fail = state == IDLE && br_pred_vld && !br_pred_succ;
  always_comb begin
    for (int i = 0; i <= SPEC_DEPTH; i++) nxt_map[i] = br_pred_succ_nxt_levels[i*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
    for (int r = 0; r < NUM_REG; r++) spec_pending[r] = |lvl[r];
  end
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    lvl_nxt = lvl;
    flag_nxt = flag;
    if (state == IDLE) begin
      if (fail) begin
        for (int r = 0; r < NUM_REG; r++) flag_nxt[r] = lvl[r] != '0 && lvl[r] >= br_pred_fail_level;
        ptr_nxt = '0;
        state_nxt = SQUASH;
      end else begin
        if (br_pred_vld) for (int r = 0; r < NUM_REG; r++) lvl_nxt[r] = nxt_map[lvl[r]];
        if (wr_vld) lvl_nxt[wr_reg] = cur_spec_level;
      end
    end else if (state == SQUASH) begin
      if (!flag[ptr] || squash_rdy) begin
        lvl_nxt[ptr] = flag[ptr] ? '0 : lvl[ptr];
        flag_nxt[ptr] = 1'b0;
        ptr_nxt = ptr + REG_ID_BIT'(1);
        state_nxt = ptr == REG_ID_BIT'(NUM_REG - 1) ? REDIRECT : SQUASH;
      end
    end else if (redirect_rdy) begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      flag <= '0;
      lvl <= '{default: '0};
      busy <= 1'b0;
      squash_vld <= 1'b0;
      squash_reg <= '0;
      redirect_vld <= 1'b0;
      redirect_pc <= '0;
      redirect_id <= '0;
      redirect_tag_map <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      flag <= flag_nxt;
      lvl <= lvl_nxt;
      busy <= state_nxt != IDLE;
      squash_vld <= state_nxt == SQUASH && flag_nxt[ptr_nxt];
      squash_reg <= ptr_nxt;
      redirect_vld <= state_nxt == REDIRECT;
      if (fail) begin
        redirect_pc <= br_pred_fail_pc;
        redirect_id <= br_pred_fail_id;
        redirect_tag_map <= br_pred_fail_tag_map;
      end
    end
  end
endmodule

// File: tb/tb_spec_rollback_ctrl.sv
// tb_spec_rollback_ctrl: table, directed and randomized checks of spec_rollback_ctrl against a level-array model
module tb_spec_rollback_ctrl;
  localparam int NR = 8;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_vld, br_pred_vld, br_pred_succ, busy, squash_vld, squash_rdy, redirect_vld, redirect_rdy;
  logic [2:0] wr_reg, cur_spec_level, br_pred_fail_level, squash_reg;
  logic [14:0] br_pred_succ_nxt_levels;
  logic [11:0] br_pred_fail_tag_map, redirect_tag_map;
  logic [3:0] br_pred_fail_pc, redirect_pc;
  logic [7:0] br_pred_fail_id, redirect_id, spec_pending;
  always #5 clk = ~clk;
  spec_rollback_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_reg(wr_reg), .cur_spec_level(cur_spec_level),
    .br_pred_vld(br_pred_vld), .br_pred_succ(br_pred_succ), .br_pred_succ_nxt_levels(br_pred_succ_nxt_levels),
    .br_pred_fail_level(br_pred_fail_level), .br_pred_fail_tag_map(br_pred_fail_tag_map),
    .br_pred_fail_pc(br_pred_fail_pc), .br_pred_fail_id(br_pred_fail_id), .busy(busy),
    .spec_pending(spec_pending), .squash_vld(squash_vld), .squash_reg(squash_reg), .squash_rdy(squash_rdy),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .redirect_id(redirect_id),
    .redirect_tag_map(redirect_tag_map), .redirect_rdy(redirect_rdy)
  );
  typedef struct {
    logic wv;
    logic [2:0] wr;
    logic [2:0] cl;
    logic sv;
    logic [14:0] map;
    logic [7:0] exp;
  } vec_t;
  typedef struct {
    logic sv;
    logic [2:0] sr;
    logic rv;
    logic srdy;
    logic rrdy;
  } rec_t;
  localparam logic [14:0] DEC = 15'h3440;
  localparam logic [14:0] IDN = 15'h4688;
  vec_t vt[11];
  int n_cmp = 0;
  int n_bad = 0;
  int m_lvl[NR];
  int sq_dly[NR];
  int rd_dly;
  logic [3:0] exp_pc;
  logic [7:0] exp_id;
  logic [11:0] exp_map;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    wr_vld = 1'b0;
    br_pred_vld = 1'b0;
    br_pred_succ = 1'b0;
    squash_rdy = 1'b0;
    redirect_rdy = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    idle_in();
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < NR; r++) m_lvl[r] = 0;
  endtask
  task automatic write(input int r, input int l);
    wr_vld = 1'b1;
    wr_reg = 3'(r);
    cur_spec_level = 3'(l);
    tick();
    idle_in();
  endtask
  task automatic drive_fail(input int fl, input logic [3:0] pc, input logic [7:0] id, input logic [11:0] mp);
    br_pred_vld = 1'b1;
    br_pred_succ = 1'b0;
    br_pred_fail_level = 3'(fl);
    br_pred_fail_pc = pc;
    br_pred_fail_id = id;
    br_pred_fail_tag_map = mp;
    exp_pc = pc;
    exp_id = id;
    exp_map = mp;
  endtask
  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    for (int r = 0; r < NR; r++) p[r] = m_lvl[r] != 0;
    return p;
  endfunction
  task automatic recover(input logic [7:0] mask, input logic [7:0] exp_pend);
    rec_t q[$];
    for (int r = 0; r < NR; r++) begin
      if (mask[r]) begin
        for (int d = 0; d < sq_dly[r]; d++) q.push_back('{1'b1, 3'(r), 1'b0, 1'b0, 1'b0});
        q.push_back('{1'b1, 3'(r), 1'b0, 1'b1, 1'b0});
      end else begin
        q.push_back('{1'b0, 3'(r), 1'b0, 1'($urandom_range(0, 1)), 1'b0});
      end
    end
    for (int d = 0; d < rd_dly; d++) q.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    q.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b1});
    tick();
    idle_in();
    foreach (q[k]) begin
      squash_rdy = q[k].srdy;
      redirect_rdy = q[k].rrdy;
      chk("rec_busy", 32'(busy), 32'(1));
      chk("squash_vld", 32'(squash_vld), 32'(q[k].sv));
      if (q[k].sv) chk("squash_reg", 32'(squash_reg), 32'(q[k].sr));
      chk("redirect_vld", 32'(redirect_vld), 32'(q[k].rv));
      if (q[k].rv) begin
        chk("redirect_pc", 32'(redirect_pc), 32'(exp_pc));
        chk("redirect_id", 32'(redirect_id), 32'(exp_id));
        chk("redirect_map", 32'(redirect_tag_map), 32'(exp_map));
      end
      tick();
    end
    idle_in();
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_squash_vld", 32'(squash_vld), 32'(0));
    chk("post_redirect_vld", 32'(redirect_vld), 32'(0));
    chk("post_pending", 32'(spec_pending), 32'(exp_pend));
  endtask
  initial begin
    vt[0] = '{1'b1, 3'd3, 3'd2, 1'b0, IDN, 8'h08};
    vt[1] = '{1'b1, 3'd1, 3'd1, 1'b0, IDN, 8'h0A};
    vt[2] = '{1'b1, 3'd2, 3'd2, 1'b0, IDN, 8'h0E};
    vt[3] = '{1'b1, 3'd5, 3'd3, 1'b0, IDN, 8'h2E};
    vt[4] = '{1'b1, 3'd3, 3'd0, 1'b0, IDN, 8'h26};
    vt[5] = '{1'b0, 3'd0, 3'd0, 1'b1, DEC, 8'h24};
    vt[6] = '{1'b1, 3'd0, 3'd1, 1'b1, DEC, 8'h21};
    vt[7] = '{1'b0, 3'd0, 3'd0, 1'b1, IDN, 8'h21};
    vt[8] = '{1'b0, 3'd0, 3'd0, 1'b1, DEC, 8'h00};
    vt[9] = '{1'b1, 3'd7, 3'd4, 1'b0, IDN, 8'h80};
    vt[10] = '{1'b0, 3'd0, 3'd0, 1'b1, DEC, 8'h80};
    wr_reg = '0;
    cur_spec_level = '0;
    br_pred_succ_nxt_levels = '0;
    br_pred_fail_level = '0;
    br_pred_fail_tag_map = '0;
    br_pred_fail_pc = '0;
    br_pred_fail_id = '0;
    idle_in();
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_squash_vld", 32'(squash_vld), 32'(0));
    chk("rst_squash_reg", 32'(squash_reg), 32'(0));
    chk("rst_redirect_vld", 32'(redirect_vld), 32'(0));
    chk("rst_pending", 32'(spec_pending), 32'(0));
    chk("rst_redirect_pc", 32'(redirect_pc), 32'(0));
    rst_n = 1'b1;
    foreach (vt[i]) begin
      wr_vld = vt[i].wv;
      wr_reg = vt[i].wr;
      cur_spec_level = vt[i].cl;
      br_pred_vld = vt[i].sv;
      br_pred_succ = 1'b1;
      br_pred_succ_nxt_levels = vt[i].map;
      tick();
      idle_in();
      chk($sformatf("vec%0d_pending", i), 32'(spec_pending), 32'(vt[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(0));
    end
    do_reset();
    write(1, 1);
    write(2, 2);
    write(5, 3);
    for (int r = 0; r < NR; r++) sq_dly[r] = 0;
    rd_dly = 0;
    drive_fail(2, 4'hA, 8'h5C, 12'h6C9);
    wr_vld = 1'b1;
    wr_reg = 3'd6;
    cur_spec_level = 3'd1;
    recover(8'h24, 8'h02);
    write(2, 3);
    write(6, 2);
    sq_dly[2] = 3;
    drive_fail(2, 4'h3, 8'h11, 12'h123);
    recover(8'h44, 8'h02);
    sq_dly[2] = 0;
    write(4, 2);
    rd_dly = 2;
    drive_fail(3, 4'h7, 8'hE1, 12'hFA5);
    recover(8'h00, 8'h12);
    rd_dly = 0;
    drive_fail(1, 4'h9, 8'h42, 12'h0F0);
    wr_vld = 1'b1;
    wr_reg = 3'd7;
    cur_spec_level = 3'd3;
    tick();
    idle_in();
    squash_rdy = 1'b1;
    repeat (NR) tick();
    squash_rdy = 1'b0;
    chk("redir_before_rst", 32'(redirect_vld), 32'(1));
    chk("redir_pending", 32'(spec_pending), 32'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_redirect_vld", 32'(redirect_vld), 32'(0));
    chk("abort_squash_vld", 32'(squash_vld), 32'(0));
    chk("abort_redirect_pc", 32'(redirect_pc), 32'(0));
    chk("abort_redirect_id", 32'(redirect_id), 32'(0));
    chk("abort_redirect_map", 32'(redirect_tag_map), 32'(0));
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int k;
      int wr;
      int cl;
      logic wv;
      k = $urandom_range(0, 99);
      wv = 1'($urandom_range(0, 1));
      wr = $urandom_range(0, NR - 1);
      cl = $urandom_range(0, SD);
      wr_vld = wv;
      wr_reg = 3'(wr);
      cur_spec_level = 3'(cl);
      if (k < 20) begin
        int fl;
        logic [7:0] mask;
        fl = $urandom_range(0, SD);
        for (int r = 0; r < NR; r++) begin
          mask[r] = m_lvl[r] != 0 && m_lvl[r] >= fl;
          if (mask[r]) m_lvl[r] = 0;
          sq_dly[r] = $urandom_range(0, 2);
        end
        rd_dly = $urandom_range(0, 2);
        drive_fail(fl, 4'($urandom), 8'($urandom), 12'($urandom));
        recover(mask, model_pending());
      end else begin
        if (k < 45) begin
          int nm[SD+1];
          logic [14:0] mp;
          nm[0] = 0;
          for (int j = 1; j <= SD; j++) nm[j] = $urandom_range(0, SD);
          for (int j = 0; j <= SD; j++) mp[j*3 +: 3] = 3'(nm[j]);
          br_pred_vld = 1'b1;
          br_pred_succ = 1'b1;
          br_pred_succ_nxt_levels = mp;
          for (int r = 0; r < NR; r++) m_lvl[r] = nm[m_lvl[r]];
        end
        if (wv) m_lvl[wr] = cl;
        tick();
        idle_in();
        chk("rnd_pending", 32'(spec_pending), 32'(model_pending()));
        chk("rnd_busy", 32'(busy), 32'(0));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
